// File: rtl/mux_arb_n_to_1_pkg.sv
// Shared definitions for the N-to-1 registered multiplexer/arbiter.
package mux_arb_n_to_1_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // Widest request vector the shared round-robin search supports.
    localparam int RR_MAX_REQ = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // One-hot grant for the first set request at or after (ptr+1), wrapping modulo n.
    // Returns all zeros when no request is set.
    function automatic logic [RR_MAX_REQ-1:0] rr_next_grant(
        input logic [RR_MAX_REQ-1:0] req,
        input int unsigned           ptr,
        input int unsigned           n
    );
        logic [RR_MAX_REQ-1:0] gnt;
        logic                  found;
        int unsigned           idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
            if (i <= n && !found) begin
                idx = (ptr + i) % n;
                if (req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mux_arb_n_to_1_if.sv
// Channel-side and consumer-side handshake bundle of the N-to-1 multiplexer.
interface mux_arb_n_to_1_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

endinterface

// File: rtl/mux_arb_n_to_1_rr_arbiter.sv
// Round-robin arbiter: pointer register plus one-hot grant; pointer moves only on advance.
module mux_arb_n_to_1_rr_arbiter
    import mux_arb_n_to_1_pkg::*;
#(
    parameter int NUM_IN = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN-1:0]         req,
    input  logic                      advance,
    output logic [NUM_IN-1:0]         grant,
    output logic [$clog2(NUM_IN)-1:0] grant_idx
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [SEL_W-1:0]      ptr;
    logic [RR_MAX_REQ-1:0] gnt_full;

    // Search upward from ptr+1 and encode the winning channel.
    always_comb begin
        gnt_full  = rr_next_grant(RR_MAX_REQ'(req), 32'(ptr), NUM_IN);
        grant     = gnt_full[NUM_IN-1:0];
        grant_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) grant_idx = SEL_W'(i);
        end
    end

    // Pointer starts at the last channel so channel 0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ptr <= SEL_W'(NUM_IN - 1);
        else if (advance) ptr <= grant_idx;
    end

endmodule

// File: rtl/mux_arb_n_to_1.sv
// Registered N-to-1 word multiplexer with valid/ready handshake; explicit select or round-robin.
module mux_arb_n_to_1
    import mux_arb_n_to_1_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int MODE   = MUX_MODE_SEL
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_arb_n_to_1_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    out_state_t       state, state_nxt;
    logic             load_en;
    logic             transfer;
    logic [NUM_IN-1:0] in_ready_int;
    logic [SEL_W-1:0] xfer_idx;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_src_q;

    assign load_en = (state == ST_EMPTY) || bus.out_ready;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [NUM_IN-1:0] grant;
            logic [SEL_W-1:0]  grant_idx;

            mux_arb_n_to_1_rr_arbiter #(.NUM_IN(NUM_IN)) u_rr_arbiter (
                .clk       (clk),
                .rst_n     (rst_n),
                .req       (bus.in_valid),
                .advance   (transfer),
                .grant     (grant),
                .grant_idx (grant_idx)
            );

            assign in_ready_int = load_en ? grant : '0;
            assign xfer_idx     = grant_idx;
        end else begin : g_sel
            // Out-of-range selects (non-power-of-two NUM_IN) pick no channel at all.
            logic sel_ok;
            assign sel_ok       = {1'b0, bus.sel} < (SEL_W+1)'(NUM_IN);
            assign in_ready_int = (load_en && sel_ok) ? (NUM_IN'(1) << bus.sel) : '0;
            assign xfer_idx     = bus.sel;
        end
    endgenerate

    assign transfer = |(bus.in_valid & in_ready_int);

    // Word mux driven only by the chosen index, so in_data never reaches an output combinationally.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (xfer_idx == SEL_W'(i)) sel_word = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output register occupancy: a load wins over a drain in the same cycle.
    always_comb begin
        state_nxt = state;
        if (transfer)                                 state_nxt = ST_FULL;
        else if (state == ST_FULL && bus.out_ready)   state_nxt = ST_EMPTY;
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Data and source tag load on transfer and otherwise hold their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_src_q  <= '0;
        end else if (transfer) begin
            out_data_q <= sel_word;
            out_src_q  <= xfer_idx;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Directed bench: explicit select (4 and 3 channels) and round-robin (4 channels).
module tb_mux_arb_n_to_1;
    import mux_arb_n_to_1_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] c_words [4];
    int          exp_src [6];

    always #5 clk = ~clk;

    mux_arb_n_to_1_if #(.WIDTH(32), .NUM_IN(4)) bus_a ();
    mux_arb_n_to_1_if #(.WIDTH(32), .NUM_IN(3)) bus_b ();
    mux_arb_n_to_1_if #(.WIDTH(32), .NUM_IN(4)) bus_c ();

    mux_arb_n_to_1 #(.WIDTH(32), .NUM_IN(4), .MODE(MUX_MODE_SEL)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mux_arb_n_to_1 #(.WIDTH(32), .NUM_IN(3), .MODE(MUX_MODE_SEL)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    mux_arb_n_to_1 #(.WIDTH(32), .NUM_IN(4), .MODE(MUX_MODE_RR))  dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    task automatic test_reset();
        #2;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b want 0", bus_a.out_valid); end
        checks++; if (bus_a.out_data !== 32'h0) begin errors++; $display("FAIL reset_a_data: got %h want 0", bus_a.out_data); end
        checks++; if (bus_c.out_src !== 2'd0) begin errors++; $display("FAIL reset_c_src: got %0d want 0", bus_c.out_src); end
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", bus_b.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.sel = 2'd0;
        #1;
        checks++; if (bus_a.in_ready !== 4'b0001) begin errors++; $display("FAIL reset_a_ready: got %b want 0001", bus_a.in_ready); end
        checks++; if (bus_c.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_c_ready_idle: got %b want 0000", bus_c.in_ready); end
    endtask

    task automatic test_sel();
        @(negedge clk);
        bus_a.in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        bus_a.in_valid  = 4'b1111;
        bus_a.sel       = 2'd2;
        bus_a.out_ready = 1'b1;
        #1;
        checks++; if (bus_a.in_ready !== 4'b0100) begin errors++; $display("FAIL sel_ready: got %b want 0100", bus_a.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_a.out_data !== 32'h33333333) begin errors++; $display("FAIL sel_data: got %h want 33333333", bus_a.out_data); end
        checks++; if (bus_a.out_src !== 2'd2) begin errors++; $display("FAIL sel_src: got %0d want 2", bus_a.out_src); end
        checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL sel_valid: got %b want 1", bus_a.out_valid); end
        @(negedge clk);
        bus_a.sel = 2'd0;
        @(posedge clk); #1;
        checks++; if (bus_a.out_data !== 32'h11111111 || bus_a.out_src !== 2'd0) begin errors++; $display("FAIL sel0_data: got %h/%0d want 11111111/0", bus_a.out_data, bus_a.out_src); end
        @(negedge clk);
        bus_a.in_valid = 4'b0000;
        @(posedge clk); #1;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus_a.out_valid); end
        checks++; if (bus_a.out_data !== 32'h11111111 || bus_a.out_src !== 2'd0) begin errors++; $display("FAIL drain_hold: got %h/%0d want 11111111/0", bus_a.out_data, bus_a.out_src); end
    endtask

    task automatic test_sel_range();
        @(negedge clk);
        bus_b.in_data   = {32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        bus_b.in_valid  = 3'b111;
        bus_b.sel       = 2'd3;
        bus_b.out_ready = 1'b1;
        #1;
        checks++; if (bus_b.in_ready !== 3'b000) begin errors++; $display("FAIL range_ready: got %b want 000", bus_b.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL range_valid: got %b want 0", bus_b.out_valid); end
        @(negedge clk);
        bus_b.sel       = 2'd2;
        bus_b.out_ready = 1'b0;
        #1;
        checks++; if (bus_b.in_ready !== 3'b100) begin errors++; $display("FAIL stall_load_ready: got %b want 100", bus_b.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== 32'hA2A2A2A2) begin errors++; $display("FAIL stall_load: got %b/%h want 1/a2a2a2a2", bus_b.out_valid, bus_b.out_data); end
        @(negedge clk);
        bus_b.in_data[95:64] = 32'hB2B2B2B2;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (bus_b.in_ready !== 3'b000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 000", k, bus_b.in_ready); end
            @(posedge clk); #1;
            checks++; if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== 32'hA2A2A2A2 || bus_b.out_src !== 2'd2) begin
                errors++; $display("FAIL stall_hold[%0d]: got %b/%h/%0d want 1/a2a2a2a2/2", k, bus_b.out_valid, bus_b.out_data, bus_b.out_src);
            end
            @(negedge clk);
        end
        bus_b.out_ready = 1'b1;
        #1;
        checks++; if (bus_b.in_ready !== 3'b100) begin errors++; $display("FAIL resume_ready: got %b want 100", bus_b.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== 32'hB2B2B2B2) begin errors++; $display("FAIL resume_data: got %b/%h want 1/b2b2b2b2", bus_b.out_valid, bus_b.out_data); end
        @(negedge clk);
        bus_b.in_valid = 3'b000;
    endtask

    task automatic test_rr();
        c_words = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
        exp_src = '{0, 1, 2, 3, 0, 1};
        @(negedge clk);
        bus_c.in_data   = {c_words[3], c_words[2], c_words[1], c_words[0]};
        bus_c.in_valid  = 4'b1111;
        bus_c.out_ready = 1'b1;
        #1;
        checks++; if (bus_c.in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready: got %b want 0001", bus_c.in_ready); end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++; if (bus_c.out_valid !== 1'b1 || bus_c.out_src !== 2'(exp_src[k]) || bus_c.out_data !== c_words[exp_src[k]]) begin
                errors++; $display("FAIL rr_seq[%0d]: got %b/%0d/%h want 1/%0d/%h", k, bus_c.out_valid, bus_c.out_src, bus_c.out_data, exp_src[k], c_words[exp_src[k]]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus_c.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_c.out_valid !== 1'b0 || bus_c.out_data !== 32'h0 || bus_c.out_src !== 2'd0) begin
            errors++; $display("FAIL async_rst_out: got %b/%h/%0d want 0/0/0", bus_c.out_valid, bus_c.out_data, bus_c.out_src);
        end
        checks++; if (bus_c.in_ready !== 4'b0001) begin errors++; $display("FAIL async_rst_ready: got %b want 0001", bus_c.in_ready); end
        #1;
        rst_n = 1'b1;
        bus_c.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_c.out_valid !== 1'b1 || bus_c.out_src !== 2'd0 || bus_c.out_data !== 32'hC0C0C0C0) begin
            errors++; $display("FAIL async_rst_first_grant: got %b/%0d/%h want 1/0/c0c0c0c0", bus_c.out_valid, bus_c.out_src, bus_c.out_data);
        end
    endtask

    task automatic test_rr_stall();
        @(negedge clk);
        bus_c.in_valid = 4'b1010;
        #1;
        checks++; if (bus_c.in_ready !== 4'b0010) begin errors++; $display("FAIL rrs_ready1: got %b want 0010", bus_c.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_c.out_src !== 2'd1 || bus_c.out_data !== 32'hC1C1C1C1) begin errors++; $display("FAIL rrs_src1: got %0d/%h want 1/c1c1c1c1", bus_c.out_src, bus_c.out_data); end
        @(negedge clk);
        bus_c.out_ready = 1'b0;
        #1;
        checks++; if (bus_c.in_ready !== 4'b0000) begin errors++; $display("FAIL rrs_stall_ready: got %b want 0000", bus_c.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_c.out_valid !== 1'b1 || bus_c.out_src !== 2'd1) begin errors++; $display("FAIL rrs_stall_hold: got %b/%0d want 1/1", bus_c.out_valid, bus_c.out_src); end
        @(negedge clk);
        bus_c.out_ready = 1'b1;
        #1;
        checks++; if (bus_c.in_ready !== 4'b1000) begin errors++; $display("FAIL rrs_ready3: got %b want 1000", bus_c.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_c.out_src !== 2'd3 || bus_c.out_data !== 32'hC3C3C3C3) begin errors++; $display("FAIL rrs_src3: got %0d/%h want 3/c3c3c3c3", bus_c.out_src, bus_c.out_data); end
        #1;
        checks++; if (bus_c.in_ready !== 4'b0010) begin errors++; $display("FAIL rrs_ready_wrap: got %b want 0010", bus_c.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_c.out_src !== 2'd1 || bus_c.out_valid !== 1'b1) begin errors++; $display("FAIL rrs_src1b: got %0d/%b want 1/1", bus_c.out_src, bus_c.out_valid); end
        @(negedge clk);
        bus_c.in_valid = 4'b0000;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus_a.in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        bus_a.in_valid  = 4'b1111;
        bus_a.sel       = 2'd1;
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'h22222222 || bus_a.out_src !== 2'd1) begin
            errors++; $display("FAIL b2b_1: got %b/%h/%0d want 1/22222222/1", bus_a.out_valid, bus_a.out_data, bus_a.out_src);
        end
        @(negedge clk);
        bus_a.sel = 2'd3;
        #1;
        checks++; if (bus_a.in_ready !== 4'b1000) begin errors++; $display("FAIL b2b_ready: got %b want 1000", bus_a.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'h44444444 || bus_a.out_src !== 2'd3) begin
            errors++; $display("FAIL b2b_2: got %b/%h/%0d want 1/44444444/3", bus_a.out_valid, bus_a.out_data, bus_a.out_src);
        end
        @(negedge clk);
        bus_a.sel = 2'd0;
        @(posedge clk); #1;
        checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'h11111111 || bus_a.out_src !== 2'd0) begin
            errors++; $display("FAIL b2b_3: got %b/%h/%0d want 1/11111111/0", bus_a.out_valid, bus_a.out_data, bus_a.out_src);
        end
    endtask

    initial begin
        bus_a.in_data = '0; bus_a.in_valid = '0; bus_a.sel = '0; bus_a.out_ready = 1'b0;
        bus_b.in_data = '0; bus_b.in_valid = '0; bus_b.sel = '0; bus_b.out_ready = 1'b0;
        bus_c.in_data = '0; bus_c.in_valid = '0; bus_c.sel = '0; bus_c.out_ready = 1'b0;
        test_reset();
        test_sel();
        test_sel_range();
        test_rr();
        test_async_reset();
        test_rr_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
